// File: rtl/complex_mac_if.sv
// Handshake bundle for the complex multiply-accumulate block:
// sample input channel and result output channel.
interface complex_mac_if #(
    parameter int W     = 8,
    parameter int ACC_W = 20
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [W-1:0]     a_re;
    logic signed [W-1:0]     a_im;
    logic signed [W-1:0]     b_re;
    logic signed [W-1:0]     b_im;
    logic                    conj;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] res_re;
    logic signed [ACC_W-1:0] res_im;
    logic                    ovf;

    modport master (
        output in_valid, a_re, a_im, b_re, b_im, conj, out_ready,
        input  in_ready, out_valid, res_re, res_im, ovf
    );

    modport slave (
        input  in_valid, a_re, a_im, b_re, b_im, conj, out_ready,
        output in_ready, out_valid, res_re, res_im, ovf
    );
endinterface

// File: rtl/complex_mac.sv
// Pipelined complex multiply-accumulate: products, complex terms,
// then a saturating group accumulator that emits one result per N samples.
module complex_mac #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int ACC_W = 20
) (
    input  logic         clk,
    input  logic         rst,
    complex_mac_if.slave bus
);
    localparam int PW = 2 * W;
    localparam int TW = 2 * W + 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic signed [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

    logic adv;
    logic accept;

    logic                 s1_valid;
    logic                 s1_conj;
    logic signed [PW-1:0] p_rr;
    logic signed [PW-1:0] p_ii;
    logic signed [PW-1:0] p_ir;
    logic signed [PW-1:0] p_ri;

    logic                 s2_valid;
    logic signed [TW-1:0] t_re;
    logic signed [TW-1:0] t_im;

    logic [CW-1:0]           cnt;
    logic signed [ACC_W-1:0] acc_re;
    logic signed [ACC_W-1:0] acc_im;
    logic                    acc_ovf;

    logic                    out_valid;
    logic signed [ACC_W-1:0] res_re;
    logic signed [ACC_W-1:0] res_im;
    logic                    ovf;

    logic signed [PW-1:0]    ar_x, ai_x, br_x, bi_x;
    logic signed [TW-1:0]    rr, ii, ir, ri;
    logic signed [TW-1:0]    re_d, im_d;
    logic signed [ACC_W-1:0] ext_re, ext_im;
    logic signed [ACC_W:0]   sum_re, sum_im;
    logic                    clamp_re, clamp_im;
    logic signed [ACC_W-1:0] nxt_re, nxt_im;
    logic                    grp_ovf;
    logic                    first;
    logic                    last;

    // The whole pipeline freezes only while a result waits unconsumed.
    assign adv           = !(out_valid && !bus.out_ready);
    assign accept        = bus.in_valid && adv;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid;
    assign bus.res_re    = res_re;
    assign bus.res_im    = res_im;
    assign bus.ovf       = ovf;

    // Operand sign extension, cross-term widening and stage-3 saturation.
    always_comb begin
        ar_x   = PW'(bus.a_re);
        ai_x   = PW'(bus.a_im);
        br_x   = PW'(bus.b_re);
        bi_x   = PW'(bus.b_im);
        rr     = TW'(p_rr);
        ii     = TW'(p_ii);
        ir     = TW'(p_ir);
        ri     = TW'(p_ri);
        re_d   = s1_conj ? (rr + ii) : (rr - ii);
        im_d   = s1_conj ? (ir - ri) : (ir + ri);
        ext_re = ACC_W'(t_re);
        ext_im = ACC_W'(t_im);
        first  = (cnt == '0);
        last   = (cnt == CW'(N - 1));
        sum_re = {acc_re[ACC_W-1], acc_re} + {ext_re[ACC_W-1], ext_re};
        sum_im = {acc_im[ACC_W-1], acc_im} + {ext_im[ACC_W-1], ext_im};
        clamp_re = 1'b0;
        clamp_im = 1'b0;
        nxt_re   = ext_re;
        nxt_im   = ext_im;
        if (!first) begin
            clamp_re = sum_re[ACC_W] != sum_re[ACC_W-1];
            clamp_im = sum_im[ACC_W] != sum_im[ACC_W-1];
            nxt_re   = sum_re[ACC_W-1:0];
            nxt_im   = sum_im[ACC_W-1:0];
            if (clamp_re) nxt_re = sum_re[ACC_W] ? MINV : MAXV;
            if (clamp_im) nxt_im = sum_im[ACC_W] ? MINV : MAXV;
        end
        grp_ovf = (first ? 1'b0 : acc_ovf) | clamp_re | clamp_im;
    end

    // Stage-1 data: the four partial products of an accepted sample.
    always_ff @(posedge clk) begin
        if (accept) begin
            p_rr    <= ar_x * br_x;
            p_ii    <= ai_x * bi_x;
            p_ir    <= ai_x * br_x;
            p_ri    <= ar_x * bi_x;
            s1_conj <= bus.conj;
        end
    end

    // Stage-2 data: exact real and imaginary terms.
    always_ff @(posedge clk) begin
        if (adv && s1_valid) begin
            t_re <= re_d;
            t_im <= im_d;
        end
    end

    // Valid bits for stages 1 and 2; bubbles enter as valid = 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
        end
    end

    // Stage 3: group accumulation and the result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            acc_re    <= '0;
            acc_im    <= '0;
            acc_ovf   <= 1'b0;
            res_re    <= '0;
            res_im    <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid && last;
            if (s2_valid) begin
                acc_re  <= nxt_re;
                acc_im  <= nxt_im;
                acc_ovf <= grp_ovf;
                cnt     <= last ? '0 : cnt + CW'(1);
                if (last) begin
                    res_re <= nxt_re;
                    res_im <= nxt_im;
                    ovf    <= grp_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_complex_mac.sv
// Scoreboard bench for complex_mac: three instances (N=1, N=4, N=8 with
// an 18-bit accumulator) driven by directed vectors.
module tb_complex_mac;
    typedef struct packed {
        logic signed [19:0] re;
        logic signed [19:0] im;
        logic               ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    exp_t               q[3][$];
    bit                 hold[3];
    logic signed [19:0] hre[3];
    logic signed [19:0] him[3];
    logic               hov[3];

    complex_mac_if #(.W(8), .ACC_W(20)) i1 ();
    complex_mac_if #(.W(8), .ACC_W(20)) i4 ();
    complex_mac_if #(.W(8), .ACC_W(18)) i8 ();

    complex_mac #(.W(8), .N(1), .ACC_W(20)) d1 (.clk(clk), .rst(rst), .bus(i1));
    complex_mac #(.W(8), .N(4), .ACC_W(20)) d4 (.clk(clk), .rst(rst), .bus(i4));
    complex_mac #(.W(8), .N(8), .ACC_W(18)) d8 (.clk(clk), .rst(rst), .bus(i8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic signed [31:0] got,
                       input logic signed [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    task automatic mon(input int d, input logic ov, input logic ordy,
                       input logic irdy, input logic signed [19:0] re,
                       input logic signed [19:0] im, input logic o);
        exp_t e;
        if (hold[d] && ov) begin
            checks++;
            if (re !== hre[d] || im !== him[d] || o !== hov[d]) begin
                errors++;
                $display("FAIL hold%0d: got %0d,%0d,%0b held %0d,%0d,%0b",
                         d, re, im, o, hre[d], him[d], hov[d]);
            end
        end
        if (ov && !ordy) begin
            chk($sformatf("stall_in_ready%0d", d), irdy, 0);
            hold[d] = 1'b1;
            hre[d]  = re;
            him[d]  = im;
            hov[d]  = o;
        end else begin
            hold[d] = 1'b0;
        end
        if (ov && ordy) begin
            checks++;
            if (q[d].size() == 0) begin
                errors++;
                $display("FAIL extra%0d: got %0d,%0d,%0b, expected none",
                         d, re, im, o);
            end else begin
                e = q[d].pop_front();
                if (re !== e.re || im !== e.im || o !== e.ovf) begin
                    errors++;
                    $display("FAIL result%0d: got %0d,%0d,%0b expected %0d,%0d,%0b",
                             d, re, im, o, e.re, e.im, e.ovf);
                end
            end
        end
    endtask

    // Monitor: consumes are decided by levels stable across the negedge.
    always @(negedge clk) begin
        mon(0, i1.out_valid, i1.out_ready, i1.in_ready, i1.res_re, i1.res_im, i1.ovf);
        mon(1, i4.out_valid, i4.out_ready, i4.in_ready, i4.res_re, i4.res_im, i4.ovf);
        mon(2, i8.out_valid, i8.out_ready, i8.in_ready, i8.res_re, i8.res_im, i8.ovf);
    end

    task automatic set_in(input int d, input logic v, input int ar, input int ai,
                          input int br, input int bi, input logic cj);
        case (d)
            0: begin
                i1.in_valid = v; i1.conj = cj;
                i1.a_re = 8'(ar); i1.a_im = 8'(ai);
                i1.b_re = 8'(br); i1.b_im = 8'(bi);
            end
            1: begin
                i4.in_valid = v; i4.conj = cj;
                i4.a_re = 8'(ar); i4.a_im = 8'(ai);
                i4.b_re = 8'(br); i4.b_im = 8'(bi);
            end
            default: begin
                i8.in_valid = v; i8.conj = cj;
                i8.a_re = 8'(ar); i8.a_im = 8'(ai);
                i8.b_re = 8'(br); i8.b_im = 8'(bi);
            end
        endcase
    endtask

    function automatic logic rdy(input int d);
        case (d)
            0:       return i1.in_ready;
            1:       return i4.in_ready;
            default: return i8.in_ready;
        endcase
    endfunction

    function automatic logic ov_of(input int d);
        case (d)
            0:       return i1.out_valid;
            1:       return i4.out_valid;
            default: return i8.out_valid;
        endcase
    endfunction

    // Present a sample from posedge+1 until it is accepted.
    task automatic send(input int d, input int ar, input int ai,
                        input int br, input int bi, input logic cj);
        bit ok;
        ok = 0;
        set_in(d, 1'b1, ar, ai, br, bi, cj);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rdy(d)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout%0d: in_ready stayed 0, expected 1", d);
        end
        @(posedge clk);
        #1;
        set_in(d, 1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int d);
        for (int k = 0; k < 300 && q[d].size() != 0; k++) @(posedge clk);
        chk($sformatf("drain%0d_left", d), q[d].size(), 0);
        idle(8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        for (int d = 0; d < 3; d++) set_in(d, 1'b0, 0, 0, 0, 0, 1'b0);
        i1.out_ready = 1'b1;
        i4.out_ready = 1'b1;
        i8.out_ready = 1'b1;
        #3;
        chk("rst_out_valid1", i1.out_valid, 0);
        chk("rst_in_ready1", i1.in_ready, 1);
        chk("rst_res_re1", i1.res_re, 0);
        chk("rst_ovf8", i8.ovf, 0);
        chk("rst_res_im8", i8.res_im, 0);
        chk("rst_out_valid4", i4.out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // N=1 plain multiply, latency 2 edges after the accept edge.
        q[0].push_back('{re: 7, im: 22, ovf: 0});
        send(0, 3, 2, 5, 4, 1'b0);
        chk("lat_e0", i1.out_valid, 0);
        idle(1);
        chk("lat_e1", i1.out_valid, 0);
        idle(1);
        chk("lat_e2", i1.out_valid, 1);
        drain(0);

        // Alternating conj every sample.
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) q[0].push_back('{re: 7, im: 22, ovf: 0});
            else            q[0].push_back('{re: 23, im: -2, ovf: 0});
            send(0, 3, 2, 5, 4, 1'(k % 2));
        end
        drain(0);

        // N=4 group with bubbles: (1+1j)^2 = 2j, four of them.
        q[1].push_back('{re: 0, im: 8, ovf: 0});
        send(1, 1, 1, 1, 1, 1'b0);
        send(1, 1, 1, 1, 1, 1'b0);
        idle(1);
        send(1, 1, 1, 1, 1, 1'b0);
        idle(1);
        send(1, 1, 1, 1, 1, 1'b0);
        drain(1);

        // N=8, ACC_W=18: real part saturates, then a clean zero group.
        q[2].push_back('{re: 131071, im: 1024, ovf: 1});
        for (int k = 0; k < 8; k++) send(2, -128, 127, -128, -128, 1'b0);
        q[2].push_back('{re: 0, im: 0, ovf: 0});
        for (int k = 0; k < 8; k++) send(2, 0, 0, 0, 0, 1'b0);
        drain(2);

        // Backpressure: (k+1j)*(2-1j) = (2k+1) + (2-k)j.
        for (int k = 1; k <= 10; k++)
            q[0].push_back('{re: 20'(2 * k + 1), im: 20'(2 - k), ovf: 0});
        fork
            begin
                for (int k = 1; k <= 10; k++) send(0, k, 1, 2, -1, 1'b0);
            end
            begin
                i1.out_ready = 1'b0;
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (i1.out_valid) break;
                end
                idle(5);
                for (int k = 0; k < 40; k++) begin
                    i1.out_ready = 1'($urandom_range(0, 1));
                    idle(1);
                end
                i1.out_ready = 1'b1;
            end
        join
        drain(0);

        // Reset mid-group while a result is also waiting.
        i4.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) send(1, 1, 1, 1, 1, 1'b0);
        chk("pre_rst_valid4", ov_of(1), 1);
        chk("pre_rst_im4", i4.res_im, 8);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid4", i4.out_valid, 0);
        chk("async_rst_im4", i4.res_im, 0);
        #2;
        rst = 1'b0;
        i4.out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready4", i4.in_ready, 1);
        idle(1);
        q[1].push_back('{re: 4, im: 0, ovf: 0});
        for (int k = 0; k < 4; k++) send(1, 1, 0, 1, 0, 1'b0);
        drain(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/complex_mac.md
COMPLEX_MAC -- requirements
Module: complex_mac

Interface
REQ-001 Parameter W, default 8: signed input component width; W >= 2.
REQ-002 Parameter N, default 4: number of products summed per output; N >= 1.
REQ-003 Parameter ACC_W, default 20: signed accumulator/result width; ACC_W >= 2*W+2.
REQ-004 Ports are listed below as name, direction, width, meaning; clock and reset come first.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 in_valid  in  1  input sample valid.
REQ-008 in_ready  out  1  block can accept a sample this cycle.
REQ-009 a_re, a_im  in  W each  operand A, signed two's complement.
REQ-010 b_re, b_im  in  W each  operand B, signed two's complement.
REQ-011 conj  in  1  per-sample mode: 0 = A*B, 1 = A*conj(B); sampled with the input.
REQ-012 out_valid  out  1  result valid.
REQ-013 out_ready  in  1  downstream accepts result.
REQ-014 res_re, res_im  out  ACC_W each  accumulated complex result, signed.
REQ-015 ovf  out  1  saturation occurred on either component in the group for this result.

Function
REQ-016 Transfer in: a sample is accepted on an edge where in_valid && in_ready; out: a result is consumed on an edge where out_valid && out_ready.
REQ-017 Stall: adv = !(out_valid && !out_ready); in_ready = adv, combinational; when adv = 0, every pipeline register holds its value.
REQ-018 Stage 1: on the accept edge, register the four products ar*br, ai*bi, ai*br, ar*bi (2W bits each), conj and a valid bit; a bubble (no accept, adv = 1) registers valid = 0.
REQ-019 Stage 2, conj = 0: re = ar*br - ai*bi, im = ai*br + ar*bi.
REQ-020 Stage 2, conj = 1: re = ar*br + ai*bi, im = ai*br - ar*bi.
REQ-021 Stage 2 width and timing: both terms are 2W+1 bits, exact and registered one edge after stage 1.
REQ-022 Stage 3 accumulates valid stage-2 terms into sign-extended ACC_W accumulators acc_re and acc_im.
REQ-023 Stage 3 group counter cnt runs 0..N-1; the first term of a group (cnt = 0) loads, the others add.
REQ-024 Saturating add: clamp each component to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; accumulation continues from the clamped value; the group ovf flag is the OR of every clamp event on either component.
REQ-025 Group end: when the term with cnt = N-1 is processed, load res_re, res_im and ovf from the final sums, set out_valid = 1 and reset cnt to 0; N = 1 gives a plain registered complex multiply.
REQ-026 Latency: with no stall, the result appears after the 3rd rising edge counting from the accept edge of the group's Nth sample.
REQ-027 Full throughput: one sample per cycle is sustained while out_ready = 1.
REQ-028 A consume and a new group end on the same edge load the new result, and out_valid stays 1.
REQ-029 A consume with no group end clears out_valid; res_re, res_im and ovf keep their last values.
REQ-030 While out_valid && !out_ready, res_re, res_im and ovf are stable and no sample is lost or duplicated.
REQ-031 Bubbles (in_valid = 0) never advance cnt and never change the accumulators.

Reset
REQ-032 While rst = 1, immediately (asynchronously) clear all pipeline valid bits, cnt, accumulators, res_re, res_im, ovf and out_valid to 0.
REQ-033 After reset, in_ready = 1; a partial group in progress at reset is discarded, and the next accepted sample starts a new group.

Verification
REQ-034 W=8, N=1, conj=0: A=3+2j, B=5+4j accepted at edge E -> out_valid=1 after edge E+2; res=7+22j, ovf=0.
REQ-035 W=8, N=1, conj=1: A=3+2j, B=5+4j -> res=23-2j; in the same stream, alternate conj each cycle and check that the results alternate accordingly.
REQ-036 N=4, four consecutive samples A=B=1+1j, with two bubbles inserted -> exactly one result, res=0+8j, ovf=0.
REQ-037 W=8, ACC_W=18, N=8: A=-128+127j, B=-128-128j repeated 8 times -> res_re=131071 (saturated), res_im=1024, ovf=1; the next group of N=8 samples A=B=0 -> res=0, ovf=0.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles while results are pending -> in_ready=0, outputs stable; then a random out_ready pattern -> result sequence matches a reference model, with no loss or duplication.
REQ-039 Reset mid-group: N=4, accept 2 samples, pulse rst asynchronously between edges -> out_valid=0 at once; then 4 samples A=B=1+0j -> res=4+0j.
